// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_pkg
//  Description : Shared encodings for the multicycle RV32I core: opcodes,
//                ALU_CO codes, ALU operand/result mux selects, control-FSM
//                state encoding and the DECODE dispatch function.
//  Revision    : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

    // RV32I major opcodes (IR[6:0])
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

    // ALU_CO codes understood by ALU_Control
    localparam logic [1:0] c_ALU_CO_ADD  = 2'b00;
    localparam logic [1:0] c_ALU_CO_SUB  = 2'b01;
    localparam logic [1:0] c_ALU_CO_FUNC = 2'b10;

    // ALU operand A select
    localparam logic [1:0] c_SRCA_PC    = 2'b00;
    localparam logic [1:0] c_SRCA_OLDPC = 2'b01;
    localparam logic [1:0] c_SRCA_RS1   = 2'b10;
    localparam logic [1:0] c_SRCA_ZERO  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] c_SRCB_RS2  = 2'b00;
    localparam logic [1:0] c_SRCB_IMM  = 2'b01;
    localparam logic [1:0] c_SRCB_FOUR = 2'b10;

    // Result bus select
    localparam logic [1:0] c_RES_ALUOUT  = 2'b00;
    localparam logic [1:0] c_RES_MEMDATA = 2'b01;
    localparam logic [1:0] c_RES_ALURES  = 2'b10;

    // Control FSM state encoding (4 bits)
    localparam logic [3:0] c_ST_FETCH    = 4'd0;
    localparam logic [3:0] c_ST_DECODE   = 4'd1;
    localparam logic [3:0] c_ST_MEMADR   = 4'd2;
    localparam logic [3:0] c_ST_MEMREAD  = 4'd3;
    localparam logic [3:0] c_ST_MEMWB    = 4'd4;
    localparam logic [3:0] c_ST_MEMWRITE = 4'd5;
    localparam logic [3:0] c_ST_EXECR    = 4'd6;
    localparam logic [3:0] c_ST_EXECI    = 4'd7;
    localparam logic [3:0] c_ST_ALUWB    = 4'd8;
    localparam logic [3:0] c_ST_BRANCH   = 4'd9;
    localparam logic [3:0] c_ST_JALRADR  = 4'd10;
    localparam logic [3:0] c_ST_JAL      = 4'd11;
    localparam logic [3:0] c_ST_UPPER    = 4'd12;
    localparam logic [3:0] c_ST_ILLEGAL  = 4'd13;

    typedef enum logic [3:0] {
        ST_FETCH    = c_ST_FETCH,
        ST_DECODE   = c_ST_DECODE,
        ST_MEMADR   = c_ST_MEMADR,
        ST_MEMREAD  = c_ST_MEMREAD,
        ST_MEMWB    = c_ST_MEMWB,
        ST_MEMWRITE = c_ST_MEMWRITE,
        ST_EXECR    = c_ST_EXECR,
        ST_EXECI    = c_ST_EXECI,
        ST_ALUWB    = c_ST_ALUWB,
        ST_BRANCH   = c_ST_BRANCH,
        ST_JALRADR  = c_ST_JALRADR,
        ST_JAL      = c_ST_JAL,
        ST_UPPER    = c_ST_UPPER,
        ST_ILLEGAL  = c_ST_ILLEGAL
    } state_e;

    // Bundle of all control outputs; all-zero is the idle/no-request value
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_co;
        logic       is_immediate;
        logic [1:0] result_src;
        logic       instr_done;
        logic       trap;
    } ctrl_t;

    // State that follows DECODE for a given opcode; unknown opcodes trap
    function automatic state_e decode_next(input logic [6:0] op);
        state_e nxt;
        case (op)
            c_OP_LOAD, c_OP_STORE: nxt = ST_MEMADR;
            c_OP_RTYPE:            nxt = ST_EXECR;
            c_OP_ITYPE:            nxt = ST_EXECI;
            c_OP_BRANCH:           nxt = ST_BRANCH;
            c_OP_JAL:              nxt = ST_JAL;
            c_OP_JALR:             nxt = ST_JALRADR;
            c_OP_LUI, c_OP_AUIPC:  nxt = ST_UPPER;
            default:               nxt = ST_ILLEGAL;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Main control FSM of the multicycle RV32I core. Sequences
//                fetch/decode/execute/memory/writeback, drives ALU_CO and
//                is_immediate to ALU_Control, stalls on memory ready, traps
//                on illegal opcodes and counts retired instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [6:0]           opcode_i,
    input  logic                 branch_taken_i,
    input  logic                 mem_ready_i,
    output logic                 pc_write_o,
    output logic                 ir_write_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic                 iord_o,
    output logic                 reg_write_o,
    output logic [1:0]           alu_src_a_o,
    output logic [1:0]           alu_src_b_o,
    output logic [1:0]           ALU_CO_o,
    output logic                 is_immediate_o,
    output logic [1:0]           result_src_o,
    output logic                 instr_done_o,
    output logic                 trap_o,
    output logic [CNT_WIDTH-1:0] instret_o
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_e                 r_state_q;
    state_e                 w_state_d;
    logic [CNT_WIDTH-1:0]   r_instret_q;
    logic [CNT_WIDTH-1:0]   w_instret_d;
    ctrl_t                  w_ctrl;
    ctrl_t                  w_ctrl_out;

    // State register and retired-instruction counter, cleared asynchronously
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state_q   <= ST_FETCH;
            r_instret_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_instret_q <= w_instret_d;
        end
    end

    // Next-state and per-state control decode (Moore, except FETCH/MEMWRITE/BRANCH gating)
    always_comb begin
        w_state_d = r_state_q;
        w_ctrl    = '0;
        case (r_state_q)
            ST_FETCH: begin
                // PC+4 computed combinationally and written straight to PC
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.alu_src_a  = c_SRCA_PC;
                w_ctrl.alu_src_b  = c_SRCB_FOUR;
                w_ctrl.alu_co     = c_ALU_CO_ADD;
                w_ctrl.result_src = c_RES_ALURES;
                if (mem_ready_i) begin
                    w_ctrl.ir_write = 1'b1;
                    w_ctrl.pc_write = 1'b1;
                    w_state_d       = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Speculatively form the branch/JAL target in ALUOut
                w_ctrl.alu_src_a = c_SRCA_OLDPC;
                w_ctrl.alu_src_b = c_SRCB_IMM;
                w_ctrl.alu_co    = c_ALU_CO_ADD;
                w_state_d        = decode_next(opcode_i);
            end
            ST_MEMADR: begin
                w_ctrl.alu_src_a = c_SRCA_RS1;
                w_ctrl.alu_src_b = c_SRCB_IMM;
                w_ctrl.alu_co    = c_ALU_CO_ADD;
                // opcode bit 5 separates store (1) from load (0)
                w_state_d        = opcode_i[5] ? ST_MEMWRITE : ST_MEMREAD;
            end
            ST_MEMREAD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b1;
                if (mem_ready_i) begin
                    w_state_d = ST_MEMWB;
                end
            end
            ST_MEMWB: begin
                w_ctrl.result_src = c_RES_MEMDATA;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
                w_state_d         = ST_FETCH;
            end
            ST_MEMWRITE: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.iord      = 1'b1;
                if (mem_ready_i) begin
                    w_ctrl.instr_done = 1'b1;
                    w_state_d         = ST_FETCH;
                end
            end
            ST_EXECR: begin
                w_ctrl.alu_src_a    = c_SRCA_RS1;
                w_ctrl.alu_src_b    = c_SRCB_RS2;
                w_ctrl.alu_co       = c_ALU_CO_FUNC;
                w_ctrl.is_immediate = 1'b0;
                w_state_d           = ST_ALUWB;
            end
            ST_EXECI: begin
                w_ctrl.alu_src_a    = c_SRCA_RS1;
                w_ctrl.alu_src_b    = c_SRCB_IMM;
                w_ctrl.alu_co       = c_ALU_CO_FUNC;
                w_ctrl.is_immediate = 1'b1;
                w_state_d           = ST_ALUWB;
            end
            ST_ALUWB: begin
                w_ctrl.result_src = c_RES_ALUOUT;
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.instr_done = 1'b1;
                w_state_d         = ST_FETCH;
            end
            ST_BRANCH: begin
                // Comparator runs on rs1-rs2; PC takes the target from DECODE
                w_ctrl.alu_src_a  = c_SRCA_RS1;
                w_ctrl.alu_src_b  = c_SRCB_RS2;
                w_ctrl.alu_co     = c_ALU_CO_SUB;
                w_ctrl.result_src = c_RES_ALUOUT;
                w_ctrl.pc_write   = branch_taken_i;
                w_ctrl.instr_done = 1'b1;
                w_state_d         = ST_FETCH;
            end
            ST_JALRADR: begin
                // Replace the DECODE target with rs1+imm, then share JAL
                w_ctrl.alu_src_a = c_SRCA_RS1;
                w_ctrl.alu_src_b = c_SRCB_IMM;
                w_ctrl.alu_co    = c_ALU_CO_ADD;
                w_state_d        = ST_JAL;
            end
            ST_JAL: begin
                // PC <= target in ALUOut while ALU forms the link value oldPC+4
                w_ctrl.alu_src_a  = c_SRCA_OLDPC;
                w_ctrl.alu_src_b  = c_SRCB_FOUR;
                w_ctrl.alu_co     = c_ALU_CO_ADD;
                w_ctrl.result_src = c_RES_ALUOUT;
                w_ctrl.pc_write   = 1'b1;
                w_state_d         = ST_ALUWB;
            end
            ST_UPPER: begin
                // LUI adds imm to zero, AUIPC adds imm to oldPC
                w_ctrl.alu_src_a = opcode_i[5] ? c_SRCA_ZERO : c_SRCA_OLDPC;
                w_ctrl.alu_src_b = c_SRCB_IMM;
                w_ctrl.alu_co    = c_ALU_CO_ADD;
                w_state_d        = ST_ALUWB;
            end
            ST_ILLEGAL: begin
                // Dead end: only reset leaves this state
                w_ctrl.trap = 1'b1;
                w_state_d   = ST_ILLEGAL;
            end
            default: begin
                w_state_d = ST_FETCH;
            end
        endcase
    end

    // Counter advances on the edge that ends each instruction's done cycle
    always_comb begin
        w_instret_d = r_instret_q;
        if (w_ctrl.instr_done) begin
            w_instret_d = r_instret_q + c_CNT_ONE;
        end
    end

    // Force every control output low for as long as reset is held
    always_comb begin
        w_ctrl_out = w_ctrl;
        if (rst_i) begin
            w_ctrl_out = '0;
        end
    end

    assign pc_write_o     = w_ctrl_out.pc_write;
    assign ir_write_o     = w_ctrl_out.ir_write;
    assign mem_read_o     = w_ctrl_out.mem_read;
    assign mem_write_o    = w_ctrl_out.mem_write;
    assign iord_o         = w_ctrl_out.iord;
    assign reg_write_o    = w_ctrl_out.reg_write;
    assign alu_src_a_o    = w_ctrl_out.alu_src_a;
    assign alu_src_b_o    = w_ctrl_out.alu_src_b;
    assign ALU_CO_o       = w_ctrl_out.alu_co;
    assign is_immediate_o = w_ctrl_out.is_immediate;
    assign result_src_o   = w_ctrl_out.result_src;
    assign instr_done_o   = w_ctrl_out.instr_done;
    assign trap_o         = w_ctrl_out.trap;
    assign instret_o      = r_instret_q;

endmodule
`default_nettype wire
